shift_add_multiplier: RTL

- Sequential shift-and-add unsigned multiplier core for the SPI multiplier peripheral.
- Sits directly downstream of the peripheral control FSM, which asserts start with operands shifted in over SPI and waits for done.
- The product is then parallel-loaded into the MISO result shift register.
- Runs entirely on the system clock; one partial-product step per cycle.

---
 rtl/shift_add_multiplier.sv | 115 +++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Unsigned shift-and-add multiplier: WIDTH cycles from start accept to done; start is a level and is re-armed only after dropping in DONE.
// MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero, giving 1..WIDTH cycles.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_mplier_shr;
    logic                 w_last;

    assign w_acc_nxt    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_shr = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
    assign w_last = (r_cnt == CW'(WIDTH - 1)) || (w_mplier_shr == '0);
`else
    assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
                // Holding start through DONE must never look like a new request.
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, op_a};
                        r_mplier <= op_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= w_acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule
